// File: rtl/hilo_muldiv.sv
// MIPS HI/LO unit: architectural HI/LO plus iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Latency: mul/div DATA_W+1 cycles from acceptance to done; MTHI/MTLO visible next cycle.
// Backpressure: busy while iterating; start is dropped (not queued) unless idle and not cancelled.
module hilo_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  // Mul: acc_hi = partial product top half, acc_lo = multiplier shifting out / product bottom half.
  // Div: acc_hi = partial remainder, acc_lo = dividend shifting out / quotient shifting in.
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic              neg_q, neg_d;     // negate product / quotient at commit
  logic              rneg_q, rneg_d;   // negate remainder at commit
  logic              div0_q, div0_d;
  logic              done_q, done_d;

  logic                accept;
  logic                signed_op;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W-1:0]   div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [2*DATA_W-1:0] prod, res_prod;
  logic [DATA_W-1:0]   quo, rem;

  // Request qualification and operand magnitudes (ops 0 and 2 are the signed forms).
  always_comb begin
    accept    = start && !cancel && (state_q == S_IDLE);
    signed_op = ~op[0];
    a_mag     = (signed_op && a_i[DATA_W-1]) ? -a_i : a_i;
    b_mag     = (signed_op && b_i[DATA_W-1]) ? -b_i : b_i;
  end

  // One iteration of shift-add multiply or restoring divide, plus sign fix-up for commit.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // When div_ge holds the true difference is below the divisor, so the low bits suffice.
    div_diff  = div_shift[DATA_W-1:0] - opnd_q;
    if (state_q == S_DIV) begin
      step_hi = div_ge ? div_diff : div_shift[DATA_W-1:0];
      step_lo = {acc_lo_q[DATA_W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
    end
    prod     = {step_hi, step_lo};
    res_prod = neg_q ? -prod : prod;
    quo      = neg_q ? -step_lo : step_lo;
    // With a zero divisor the remainder accumulates |a|; re-applying a's sign yields a itself.
    rem      = rneg_q ? -step_hi : step_hi;
  end

  // Next-state, datapath update and commit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            3'd0, 3'd1: begin
              state_d  = S_MUL;
              cnt_d    = '0;
              acc_hi_d = '0;
              acc_lo_d = b_mag;
              opnd_d   = a_mag;
              neg_d    = signed_op && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
              rneg_d   = 1'b0;
              div0_d   = 1'b0;
            end
            3'd2, 3'd3: begin
              state_d  = S_DIV;
              cnt_d    = '0;
              acc_hi_d = '0;
              acc_lo_d = a_mag;
              opnd_d   = b_mag;
              neg_d    = signed_op && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
              rneg_d   = signed_op && a_i[DATA_W-1];
              div0_d   = (b_i == '0);
            end
            3'd4:    hi_d = a_i;
            3'd5:    lo_d = a_i;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            if (state_q == S_MUL) begin
              hi_d = res_prod[2*DATA_W-1:DATA_W];
              lo_d = res_prod[DATA_W-1:0];
            end else begin
              hi_d = rem;
              lo_d = div0_q ? '1 : quo;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed cases plus randomized ops against an arithmetic model.
// Results are queued at issue and matched by an independent monitor on each done pulse.
// Monitor also flags any done pulse that was not expected.
module tb_hilo_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_i, b_i;
  logic         cancel;
  logic         busy, done;
  logic [W-1:0] hi_o, lo_o;

  hilo_muldiv #(.DATA_W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_i    (a_i),
    .b_i    (b_i),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] hi_m = '0, lo_m = '0;      // architectural HI/LO as the model sees them
  logic [W-1:0] pend_hi = '0, pend_lo = '0; // result of the latest issued mul/div

  function automatic void check(string name, longint unsigned act, longint unsigned req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endfunction

  // Reference: HI/LO result of a mul/div computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint sa, sb_, sq, sr;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (o)
      3'd0: p = sa * sb_;
      3'd1: p = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb_;
          sr = sa % sb_;
          p  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard, cycle-exactly.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: hi=%h lo=%h", cyc, hi_o, lo_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("done_hi", hi_o, e.hi);
        check("done_lo", lo_o, e.lo);
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  // Drive one start cycle; entered and left at #1 after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    logic [63:0] r;
    start = 1'b1; op = o; a_i = a; b_i = b;
    if (o <= 3'd3 && track) begin
      r = ref_model(o, a, b);
      pend_hi = r[63:32];
      pend_lo = r[31:0];
      sb.push_back('{hi: r[63:32], lo: r[31:0], cyc: cyc + W + 1});
    end else if (o == 3'd4) begin
      hi_m = a;
    end else if (o == 3'd5) begin
      lo_m = a;
    end
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a_i = $urandom; b_i = $urandom;
  endtask

  // Issue a mul/div and wait for the monitor to consume its result.
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int nb = 0;
    int k  = 0;
    issue(o, a, b, 1'b1);
    while (sb.size() != 0 && k < 100) begin
      if (busy) nb++;
      if (k == W / 2) begin
        check("hi_hold_while_busy", hi_o, hi_m);
        check("lo_hold_while_busy", lo_o, lo_m);
      end
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout op=%0d: got no done, expected one within %0d cycles", o, W + 1);
      sb.delete();
    end
    check("busy_cycles", 64'(nb), 64'(W));
    hi_m = pend_hi;
    lo_m = pend_lo;
  endtask

  task automatic do_any(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o <= 3'd3) begin
      run_md(o, a, b);
    end else begin
      issue(o, a, b, 1'b1);
      check("mt_hi", hi_o, hi_m);
      check("mt_lo", lo_o, lo_m);
      check("mt_no_busy", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // MTHI / MTLO
    do_any(3'd4, 32'h0000_1234, 32'h0);
    check("mthi_value", hi_o, 32'h0000_1234);
    check("mthi_lo_kept", lo_o, 32'h0);
    do_any(3'd5, 32'hCAFE_F00D, 32'h0);
    check("mtlo_value", lo_o, 32'hCAFE_F00D);
    check("mtlo_hi_kept", hi_o, 32'h0000_1234);

    // Multiply and divide corner values
    run_md(3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFFA);
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", hi_o, 32'hFFFF_FFFE);
    check("multu_lo", lo_o, 32'h0000_0001);
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);
    run_md(3'd3, 32'd7, 32'd2);
    check("divu_lo", lo_o, 32'd3);
    check("divu_hi", hi_o, 32'd1);
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", lo_o, 32'h8000_0000);
    check("div_ovf_hi", hi_o, 32'h0);
    run_md(3'd3, 32'd7, 32'd0);
    check("divu0_hi", hi_o, 32'd7);
    check("divu0_lo", lo_o, 32'hFFFF_FFFF);
    run_md(3'd2, 32'hFFFF_FFF0, 32'd0);

    // Back-to-back: second op accepted in the done cycle of the first
    issue(3'd1, 32'd12345, 32'd678, 1'b1);
    repeat (W) @(posedge clk);
    #1;
    hi_m = pend_hi;
    lo_m = pend_lo;
    check("b2b_done_seen", done, 1);
    run_md(3'd2, 32'hFFFF_0000, 32'd7);

    // start together with cancel in idle is ignored
    start = 1'b1; op = 3'd4; a_i = 32'hDEAD_BEEF; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("start_cancel_hi", hi_o, hi_m);
    check("start_cancel_busy", busy, 0);

    // Ignored MTLO while busy, then cancel, then a fresh DIVU
    issue(3'd1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);   // now cycle T+1
    repeat (4) @(posedge clk);
    #1;                                                  // T+5
    start = 1'b1; op = 3'd5; a_i = 32'h5555_AAAA;
    @(posedge clk); #1;                                  // T+6
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;                                                  // T+10
    check("busy_before_cancel", busy, 1);
    cancel = 1'b1;
    @(posedge clk); #1;                                  // T+11
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_hi", hi_o, hi_m);
    check("cancel_lo", lo_o, lo_m);
    run_md(3'd3, 32'd100, 32'd9);

    // Asynchronous reset in the middle of a divide
    issue(3'd2, 32'h8765_4321, 32'd5, 1'b0);             // T+1
    repeat (6) @(posedge clk);
    #1;                                                  // T+7
    check("busy_before_rst", busy, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_hi", hi_o, 0);
    check("arst_lo", lo_o, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    hi_m = '0;
    lo_m = '0;
    repeat (W + 8) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 0);

    // Randomized mix of all ops including no-ops
    for (int i = 0; i < 30; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      do_any(ro, pick(), pick());
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO unit for the MIPS execute stage. It holds the architectural HI and LO registers and adds an iterative multiplier/divider (MULT, MULTU, DIV, DIVU) with a busy/done handshake. It also keeps the single-cycle MTHI/MTLO writes. The pipeline stalls on `busy` and reads HI/LO directly from `hi_o`/`lo_o` for MFHI/MFLO.

## Interface
- `DATA_W`, 32: operand and HI/LO width; must be even and ≥ 4.
- `clk` input 1: single clock, all state on the rising edge.
- `rst` input 1: asynchronous, active-high reset; clears all state.
- `start` input 1: request valid this cycle.
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops.
- `a_i` input DATA_W: multiplicand/dividend, or MTHI/MTLO data.
- `b_i` input DATA_W: multiplier/divisor.
- `cancel` input 1: exception flush; aborts an in-flight operation.
- `busy` output 1: a mul/div is in progress.
- `done` output 1: one-cycle pulse when a mul/div result has been committed.
- `hi_o` output DATA_W: architectural HI.
- `lo_o` output DATA_W: architectural LO.

## Operation
- Reset values: `hi_o`=0, `lo_o`=0, `busy`=0, `done`=0, FSM=IDLE, iteration counter=0.
- FSM states:
  - IDLE → MUL on an accepted op 0/1.
  - IDLE → DIV on an accepted op 2/3.
  - MUL or DIV → IDLE after DATA_W iterations, or on `cancel`.
- Accept rule: a request is accepted only when `start`=1, FSM=IDLE and `cancel`=0.
  - A `start` while busy is ignored and not queued.
  - `start` with `cancel` in the same cycle is ignored.
- MTHI: `hi_o` ← `a_i`; `lo_o` unchanged. MTLO: `lo_o` ← `a_i`; `hi_o` unchanged. Neither raises `busy` or `done`.
- MULT/MULTU: radix-2 shift-add, one bit per cycle, over a 2·DATA_W product.
  - Signed ops multiply operand magnitudes, then negate the product if the operand signs differ.
  - Result: {HI,LO} = full 2·DATA_W product.
- DIV/DIVU: restoring division, one quotient bit per cycle.
  - LO = quotient, HI = remainder.
  - Signed ops work on magnitudes. The quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (op 2/3, `b_i`=0): runs the full latency, then HI ← `a_i`, LO ← all ones.
- Signed overflow (most-negative / −1): LO ← most-negative, HI ← 0.
- Operands are captured at acceptance; `a_i`/`b_i` are don't-care while busy.
- HI/LO change only at commit or on MTHI/MTLO. During iteration they hold their old values, so MFHI/MFLO during `busy` return the pre-op values; the pipeline is responsible for stalling.
- `cancel` while busy: the FSM returns to IDLE, HI/LO are unchanged, and no `done` is issued.
- `cancel` in IDLE has no effect.
- `rst` mid-operation: asynchronous return to the reset values; no `done`.

## Timing
- Mul/div accepted in cycle T:
  - `busy`=1 in cycles T+1 … T+DATA_W.
  - HI/LO are written at the rising edge that ends cycle T+DATA_W.
  - `done`=1 and new `hi_o`/`lo_o` are visible in cycle T+DATA_W+1; `busy`=0 in that cycle.
- Latency is DATA_W+1 cycles from acceptance to `done`, regardless of operands (including divide by zero).
- Back-to-back: a new `start` may be accepted in the `done` cycle (T+DATA_W+1).
- MTHI/MTLO accepted in cycle T: the new value is visible in T+1.
- MTHI/MTLO during `busy` are ignored, like any other `start`.
- `cancel` in a busy cycle C: `busy`=0 in C+1, and `start` can be accepted in C+1.
- `busy` and `done` are registered outputs; they are never combinational from inputs.

## Test plan
- Reset → MTHI `a_i`=0x00001234 → `hi_o`=0x00001234 the next cycle, `lo_o`=0. Then MTLO 0xCAFEF00D → `lo_o`=0xCAFEF00D, `hi_o` unchanged.
- MULT −2×3 → `busy` for 32 cycles, `done` at T+33, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 7/0 → `done` at T+33, HI=0x00000007, LO=0xFFFFFFFF.
- Start MULTU, then assert MTLO `start` at T+5 → ignored. Assert `cancel` at T+10 → `busy`=0 at T+11, HI/LO hold their old values, no `done` ever. Start DIVU at T+11 → accepted.
- Start DIV, assert `rst` at T+7 between clock edges → outputs clear to 0 immediately; no `done` after `rst` deasserts.
